// File: rtl/mem_stage.sv
// Memory stage: latches the EX pair, waits for the slot-1 load response, then aligns and extends it for write-back.
// One cycle for non-loads; loads stay until data_ok, and the response is buffered if write-back stalls.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD   = 145,
    parameter int MS_TO_WS_BUS_WD   = 141,
    parameter int MS_FORWARD_BUS_WD = 78
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ms_allowin,
    input  logic                         es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus,
    input  logic                         ws_allowin,
    output logic                         ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
    input  logic                         data_sram_data_ok,
    input  logic [31:0]                  data_sram_rdata,
    output logic [MS_FORWARD_BUS_WD-1:0] ms_forward_bus
);

    typedef struct packed {
        logic        inst2_valid;
        logic        inst2_gr_we;
        logic [4:0]  inst2_dest;
        logic [31:0] inst2_alu_result;
        logic [31:0] inst2_pc;
        logic        inst1_is_load;
        logic [2:0]  inst1_load_op;
        logic        inst1_gr_we;
        logic [4:0]  inst1_dest;
        logic [31:0] inst1_alu_result;
        logic [31:0] inst1_pc;
    } es_bus_t;

    typedef struct packed {
        logic        inst2_valid;
        logic        inst2_gr_we;
        logic [4:0]  inst2_dest;
        logic [31:0] inst2_result;
        logic [31:0] inst2_pc;
        logic        inst1_gr_we;
        logic [4:0]  inst1_dest;
        logic [31:0] inst1_result;
        logic [31:0] inst1_pc;
    } ws_bus_t;

    typedef struct packed {
        logic        ms_valid;
        logic        inst1_load_pending;
        logic        inst1_gr_we;
        logic [4:0]  inst1_dest;
        logic [31:0] inst1_result;
        logic        inst2_gr_we;
        logic [4:0]  inst2_dest;
        logic [31:0] inst2_result;
    } fwd_bus_t;

    typedef enum logic {
        LD_WAIT = 1'b0,
        LD_HOLD = 1'b1
    } ld_state_t;

    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic        ms_valid_q, ms_valid_d;
    es_bus_t     bus_q, bus_d;
    ld_state_t   state_q, state_d;
    logic [31:0] buf_data_q, buf_data_d;

    logic        ms_ready_go;
    logic        buf_valid;
    logic [1:0]  ld_addr;
    logic [31:0] ld_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] inst1_result;
    ws_bus_t     ws_out;
    fwd_bus_t    fwd_out;

    assign buf_valid = (state_q == LD_HOLD);

    // Once the response is buffered the pair no longer depends on data_ok.
    always_comb begin
        ms_ready_go = 1'b1;
        if (bus_q.inst1_is_load) begin
            ms_ready_go = buf_valid | data_sram_data_ok;
        end
    end

    assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;

    always_comb begin
        ms_valid_d = ms_valid_q;
        bus_d      = bus_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            bus_d = es_bus_t'(es_to_ms_bus);
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        case (state_q)
            LD_WAIT: begin
                if (ms_valid_q && bus_q.inst1_is_load && data_sram_data_ok && !ws_allowin) begin
                    state_d    = LD_HOLD;
                    buf_data_d = data_sram_rdata;
                end
            end
            LD_HOLD: begin
                if (ws_allowin) begin
                    state_d = LD_WAIT;
                end
            end
            default: state_d = LD_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            bus_q      <= '0;
            state_q    <= LD_WAIT;
            buf_data_q <= '0;
        end else begin
            ms_valid_q <= ms_valid_d;
            bus_q      <= bus_d;
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
        end
    end

    always_comb begin
        ld_addr = bus_q.inst1_alu_result[1:0];
        ld_word = buf_valid ? buf_data_q : data_sram_rdata;
        ld_byte = ld_word[{ld_addr, 3'b000} +: 8];
        ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
        case (bus_q.inst1_load_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = ld_word;
        endcase
        inst1_result = bus_q.inst1_is_load ? ld_data : bus_q.inst1_alu_result;
    end

    always_comb begin
        ws_out.inst2_valid  = bus_q.inst2_valid;
        ws_out.inst2_gr_we  = bus_q.inst2_gr_we;
        ws_out.inst2_dest   = bus_q.inst2_dest;
        ws_out.inst2_result = bus_q.inst2_alu_result;
        ws_out.inst2_pc     = bus_q.inst2_pc;
        ws_out.inst1_gr_we  = bus_q.inst1_gr_we;
        ws_out.inst1_dest   = bus_q.inst1_dest;
        ws_out.inst1_result = inst1_result;
        ws_out.inst1_pc     = bus_q.inst1_pc;

        fwd_out.ms_valid           = ms_valid_q;
        fwd_out.inst1_load_pending = ms_valid_q & bus_q.inst1_is_load & !ms_ready_go;
        fwd_out.inst1_gr_we        = bus_q.inst1_gr_we;
        fwd_out.inst1_dest         = bus_q.inst1_dest;
        fwd_out.inst1_result       = inst1_result;
        fwd_out.inst2_gr_we        = bus_q.inst2_gr_we;
        fwd_out.inst2_dest         = bus_q.inst2_dest;
        fwd_out.inst2_result       = bus_q.inst2_alu_result;
    end

    assign ms_to_ws_bus   = ws_out;
    assign ms_forward_bus = fwd_out;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vectors with literal expectations plus a transaction-level model compared every cycle.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         ms_allowin;
    logic         es_to_ms_valid = 1'b0;
    logic [144:0] es_to_ms_bus = '0;
    logic         ws_allowin = 1'b1;
    logic         ms_to_ws_valid;
    logic [140:0] ms_to_ws_bus;
    logic         data_sram_data_ok = 1'b0;
    logic [31:0]  data_sram_rdata = '0;
    logic [77:0]  ms_forward_bus;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_forward_bus    (ms_forward_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [144:0] mk_es(
        input logic i2v, input logic i2we, input logic [4:0] i2d, input logic [31:0] i2alu,
        input logic [31:0] i2pc, input logic ld, input logic [2:0] op, input logic i1we,
        input logic [4:0] i1d, input logic [31:0] i1alu, input logic [31:0] i1pc);
        return {i2v, i2we, i2d, i2alu, i2pc, ld, op, i1we, i1d, i1alu, i1pc};
    endfunction

    // Load extension from the ISA rules, by shifting and masking the word.
    function automatic logic [31:0] mdl_load(input logic [2:0] op, input logic [1:0] a, input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? 32'(b + 32'hFFFFFF00) : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h + 32'hFFFF0000) : 32'(h);
            3'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction

    // Model: the stage holds at most one pair, plus the load word once it has arrived.
    logic         m_full = 1'b0;
    logic         m_have = 1'b0;
    logic [31:0]  m_word = '0;
    logic [144:0] m_es = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                m_full = 1'b0;
                m_have = 1'b0;
                m_word = '0;
                m_es   = '0;
            end else begin
                logic        ld, ready, exp_allow, exp_valid, leave;
                logic [2:0]  op;
                logic [1:0]  a;
                logic [31:0] word, r1;
                logic [140:0] exp_ws;
                logic [77:0]  exp_fw;
                ld        = m_es[73];
                op        = m_es[72:70];
                a         = m_es[33:32];
                ready     = !ld || m_have || data_sram_data_ok;
                word      = m_have ? m_word : data_sram_rdata;
                r1        = ld ? mdl_load(op, a, word) : m_es[63:32];
                exp_allow = !m_full || (ready && ws_allowin);
                exp_valid = m_full && ready;
                exp_ws    = {m_es[144], m_es[143], m_es[142:138], m_es[137:106], m_es[105:74],
                             m_es[69], m_es[68:64], r1, m_es[31:0]};
                exp_fw    = {m_full, m_full && ld && !ready, m_es[69], m_es[68:64], r1,
                             m_es[143], m_es[142:138], m_es[137:106]};

                chk("mdl_allowin", 160'(ms_allowin), 160'(exp_allow));
                chk("mdl_valid", 160'(ms_to_ws_valid), 160'(exp_valid));
                chk("mdl_fwd_ctl", 160'(ms_forward_bus[77:76]), 160'(exp_fw[77:76]));
                if (exp_valid) chk("mdl_ws_bus", 160'(ms_to_ws_bus), 160'(exp_ws));
                if (m_full) chk("mdl_fwd_data", 160'(ms_forward_bus[75:0]), 160'(exp_fw[75:0]));

                assert (!(m_full && ld && op == 3'd0 && a != 2'd0)) else begin
                    errors++;
                    $display("FAIL misaligned_lw: addr offset %0d", a);
                end
                if (data_sram_data_ok && !(m_full && ld && !m_have))
                    $display("note: stray data_ok at %0t ignored", $time);

                leave = exp_valid && ws_allowin;
                if (m_full && ld && !m_have && data_sram_data_ok && !leave) begin
                    m_have = 1'b1;
                    m_word = data_sram_rdata;
                end
                if (leave) m_have = 1'b0;
                if (exp_allow) begin
                    m_full = es_to_ms_valid;
                    if (es_to_ms_valid) m_es = es_to_ms_bus;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic al, input logic [31:0] r1);
        chk({name, "_valid"}, 160'(ms_to_ws_valid), 160'(v));
        chk({name, "_allowin"}, 160'(ms_allowin), 160'(al));
        if (v) chk({name, "_result"}, 160'(ms_to_ws_bus[63:32]), 160'(r1));
    endtask

    logic [31:0] sweep_exp [4][4];
    logic [2:0]  sweep_op [4];

    initial begin
        sweep_op  = '{3'd1, 3'd2, 3'd3, 3'd4};
        sweep_exp = '{'{32'hFFFFFFBB, 32'hFFFFFFAA, 32'hFFFFFF99, 32'hFFFFFF88},
                      '{32'h000000BB, 32'h000000AA, 32'h00000099, 32'h00000088},
                      '{32'hFFFFAABB, 32'hFFFFAABB, 32'hFFFF8899, 32'hFFFF8899},
                      '{32'h0000AABB, 32'h0000AABB, 32'h00008899, 32'h00008899}};

        #2 reset = 1'b1;
        #2;
        chk("rst_valid", 160'(ms_to_ws_valid), 160'(0));
        chk("rst_allowin", 160'(ms_allowin), 160'(1));
        chk("rst_ws_bus", 160'(ms_to_ws_bus), 160'(0));
        chk("rst_fwd_bus", 160'(ms_forward_bus), 160'(0));
        cyc();
        cyc();
        reset = 1'b0;

        // Non-load pair.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 1'b1, 5'd6, 32'h22, 32'h1004, 1'b0, 3'd0, 1'b1, 5'd5, 32'h11, 32'h1000);
        #1 chk("nl_allowin_in", 160'(ms_allowin), 160'(1));
        cyc();
        es_to_ms_valid = 1'b0;
        #1 chk_out("nl", 1'b1, 1'b1, 32'h11);
        chk("nl_i1_dest", 160'(ms_to_ws_bus[68:64]), 160'(5));
        chk("nl_i2_dest", 160'(ms_to_ws_bus[138:134]), 160'(6));
        chk("nl_i2_result", 160'(ms_to_ws_bus[133:102]), 160'(32'h22));
        chk("nl_i2_valid", 160'(ms_to_ws_bus[140]), 160'(1));
        cyc();
        #1 chk("nl_after", 160'(ms_to_ws_valid), 160'(0));

        // LB at offset 3 with a three-cycle wait.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 1'b0, 5'd0, 32'h0, 32'h2004, 1'b1, 3'd1, 1'b1, 5'd7, 32'h0000_1003, 32'h2000);
        cyc();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk_out("lb_wait", 1'b0, 1'b0, 32'h0);
            chk("lb_pending", 160'(ms_forward_bus[76]), 160'(1));
            cyc();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        #1 chk_out("lb_done", 1'b1, 1'b1, 32'hFFFFFF80);
        cyc();
        data_sram_data_ok = 1'b0;
        #1 chk("lb_after", 160'(ms_to_ws_valid), 160'(0));

        // LHU at offset 2, write-back stalled for two cycles after the response.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b0, 1'b0, 5'd0, 32'h0, 32'h3004, 1'b1, 3'd4, 1'b1, 5'd8, 32'h0000_2002, 32'h3000);
        cyc();
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h8001_1234;
        #1 chk_out("lhu_ok", 1'b1, 1'b0, 32'h00008001);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        #1 chk_out("lhu_hold", 1'b1, 1'b0, 32'h00008001);
        cyc();
        ws_allowin = 1'b1;
        #1 chk_out("lhu_leave", 1'b1, 1'b1, 32'h00008001);
        cyc();
        #1 chk("lhu_after", 160'(ms_to_ws_valid), 160'(0));

        // Back-to-back LW pairs.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 1'b1, 5'd9, 32'h5, 32'h4004, 1'b1, 3'd0, 1'b1, 5'd10, 32'h0000_3000, 32'h4000);
        cyc();
        es_to_ms_bus = mk_es(1'b1, 1'b1, 5'd11, 32'h6, 32'h400C, 1'b1, 3'd0, 1'b1, 5'd12, 32'h0000_3004, 32'h4008);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_BEEF;
        #1 chk_out("lw_a", 1'b1, 1'b1, 32'hDEADBEEF);
        chk("lw_a_pc", 160'(ms_to_ws_bus[31:0]), 160'(32'h4000));
        cyc();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1 chk_out("lw_b", 1'b1, 1'b1, 32'h12345678);
        chk("lw_b_pc", 160'(ms_to_ws_bus[31:0]), 160'(32'h4008));
        cyc();
        data_sram_data_ok = 1'b0;
        #1 chk("lw_after", 160'(ms_to_ws_valid), 160'(0));

        // Every sub-word load at every offset, then word loads.
        for (int o = 0; o < 4; o++) begin
            for (int k = 0; k < 4; k++) begin
                cyc();
                es_to_ms_valid = 1'b1;
                es_to_ms_bus = mk_es(1'b0, 1'b0, 5'd0, 32'h0, 32'h5004, 1'b1, sweep_op[k], 1'b1, 5'd13,
                                     32'h0000_4000 + 32'(o), 32'h5000);
                cyc();
                es_to_ms_valid = 1'b0;
                data_sram_data_ok = 1'b1;
                data_sram_rdata = 32'h8899_AABB;
                #1 chk_out("sweep", 1'b1, 1'b1, sweep_exp[k][o]);
                cyc();
                data_sram_data_ok = 1'b0;
            end
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk_es(1'b0, 1'b0, 5'd0, 32'h0, 32'h6004, 1'b1, (k == 0) ? 3'd0 : 3'(4 + k),
                                 1'b1, 5'd14, 32'h0000_5000, 32'h6000);
            cyc();
            es_to_ms_valid = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata = 32'h8899_AABB;
            #1 chk_out("sweep_w", 1'b1, 1'b1, 32'h8899AABB);
            cyc();
            data_sram_data_ok = 1'b0;
        end

        // Asynchronous reset while waiting, with a response in the same cycle.
        cyc();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_es(1'b1, 1'b1, 5'd15, 32'h7, 32'h7004, 1'b1, 3'd0, 1'b1, 5'd16, 32'h0000_6000, 32'h7000);
        cyc();
        es_to_ms_valid = 1'b0;
        #1 chk("rw_pending", 160'(ms_forward_bus[76]), 160'(1));
        #1 reset = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h5555_AAAA;
        #1 chk_out("rw_rst", 1'b0, 1'b1, 32'h0);
        chk("rw_ws_bus", 160'(ms_to_ws_bus), 160'(0));
        chk("rw_fwd_bus", 160'(ms_forward_bus), 160'(0));
        cyc();
        data_sram_data_ok = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        data_sram_data_ok = 1'b1;
        #1 chk_out("rw_stray", 1'b0, 1'b1, 32'h0);
        cyc();
        data_sram_data_ok = 1'b0;
        #1 chk_out("rw_after", 1'b0, 1'b1, 32'h0);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
